sine_sweep_ctrl: RTL and testbench
==================================

# sine_sweep_ctrl

Frequency-sweep controller sitting directly upstream of the CORDIC `Sine` NCO. It drives the NCO's phase-increment and valid inputs (`PhInc_i` and `Val_i`). It steps the phase increment from a start value to a stop value in fixed increments, holding each value for a programmable dwell time, and produces a stepped-chirp test tone. Done is signalled at the end of the sweep.

## Interface
- `W`, 16, phase-increment width (matches NCO `PhInc_i`)
- `DWELL_W`, 16, dwell-counter width
- `Clk_i` in 1: single clock, rising edge
- `Rst_i` in 1: asynchronous, active-high reset
- `Start_i` in 1: start request, sampled only in IDLE
- `Abort_i` in 1: abort sweep, level-sampled
- `StartInc_i` in W: first phase increment
- `StopInc_i` in W: final phase increment
- `Step_i` in W: step magnitude, unsigned; 0 treated as 1
- `Dwell_i` in DWELL_W: cycles each value is held; 0 treated as 1
- `PhInc_o` out W: to NCO `PhInc_i`
- `Val_o` out 1: to NCO `Val_i`; high while a value is presented
- `Busy_o` out 1: high in any state other than IDLE
- `Done_o` out 1: one-cycle pulse when the sweep completes

## Operation
- States: IDLE, RUN, DONE.
- Reset (async, immediate): state=IDLE; `PhInc_o`=0, `Val_o`=0, `Busy_o`=0, `Done_o`=0; all internal registers cleared.
- IDLE:
  - `Start_i`=1 and `Abort_i`=0 → latch `StartInc_i`, `StopInc_i`, `Step_i`, `Dwell_i`; set `PhInc_o`=StartInc; load dwell counter with D−1, where D=max(Dwell,1); go to RUN.
  - `Start_i` and `Abort_i` high together → stay in IDLE.
- Direction is fixed at latch time: up if Stop ≥ Start (unsigned), otherwise down.
- RUN:
  - `Val_o`=1.
  - Dwell counter nonzero → decrement.
  - Dwell counter zero and `PhInc_o`==Stop → go to DONE.
  - Dwell counter zero otherwise → compute next = `PhInc_o` ± S (S=max(Step,1)) in W+1 bits. Clamp to Stop if the result passes Stop or over/underflows W bits. Load `PhInc_o`=next and reload the counter with D−1.
  - `Start_i` is ignored in RUN; latched configuration does not change mid-sweep.
- Abort: `Abort_i`=1 in RUN → next edge goes to IDLE with `Val_o`=0 and `PhInc_o`=0; no `Done_o` pulse.
- DONE: lasts exactly one cycle; `Done_o`=1, `Val_o`=0; returns to IDLE. `PhInc_o` holds the Stop value until the next start.
- Start==Stop → a single value is presented for D cycles, then DONE.

## Timing
- `Start_i` sampled at edge k → `PhInc_o`=StartInc and `Val_o`=1 from edge k (visible cycle k+1).
- Each value is presented for exactly D consecutive cycles; no gaps between steps.
- Total `Val_o` high cycles = N×D, where N = number of distinct values including the clamped Stop.
- `Done_o` asserts the cycle immediately after the last valid cycle.
- Earliest next start: the cycle after DONE (in IDLE).
- All outputs are registered; no combinational input-to-output paths.

## Configuration
- `SWEEP_LOOP_EN` defined:
  - On reaching the end of Stop's dwell, reload `PhInc_o`=StartInc and the dwell counter instead of entering DONE.
  - `Val_o` stays high and `Done_o` pulses for one cycle coincident with the reload.
  - The sweep repeats until `Abort_i`; `Busy_o` stays high.
- `SWEEP_LOOP_EN` undefined: one-shot behaviour as specified above.

## Test plan
- Ascending sweep: Start=0x0010, Stop=0x0030, Step=0x0010, Dwell=3 → `PhInc_o` = 0x10 ×3, 0x20 ×3, 0x30 ×3 with `Val_o`=1 throughout; then `Done_o` for 1 cycle, `Val_o`=0, `Busy_o`=0.
- Descending with clamp: Start=0x0030, Stop=0x0005, Step=0x0010, Dwell=1 → 0x30, 0x20, 0x10, 0x05, one cycle each; then Done.
- Overflow clamp and zero-field substitution: Start=0xFFF0, Stop=0xFFFF, Step=0x0020, Dwell=0 → 0xFFF0, 0xFFFF, one cycle each (D=1); then Done.
- Abort and priority: Abort_i on the 2nd cycle of the 0x20 dwell (first scenario's settings) → next cycle `Val_o`=0, `PhInc_o`=0, no `Done_o` pulse. Separately, Start+Abort together in IDLE → remains IDLE.
- Reset mid-sweep: `Rst_i` pulse while RUN → all outputs 0 immediately, without waiting for a clock edge. A subsequent Start with Start=Stop=0x0030, Dwell=2 → 0x30 ×2, then Done.
- `SWEEP_LOOP_EN` build: first scenario's settings → the 0x10/0x20/0x30 pattern repeats with `Done_o` at each reload to 0x10 and `Val_o` never dropping, until Abort.

Source files
------------

// File: rtl/sine_sweep_ctrl.sv
// sine_sweep_ctrl
// Stepped-chirp frequency-sweep controller feeding the CORDIC Sine NCO.
// Steps the phase increment from a start value towards a stop value in
// fixed steps, holding each value for a programmable dwell, then pulses
// Done_o.
//
// Build option:
//   SWEEP_LOOP_EN - when defined, the sweep restarts from StartInc after the
//                   stop value's dwell instead of finishing; Done_o pulses on
//                   each restart and the sweep runs until Abort_i.
//
// Ports:
//   Clk_i       clock, rising edge
//   Rst_i       asynchronous active-high reset
//   Start_i     start request (sampled in IDLE only)
//   Abort_i     abort the running sweep (level)
//   StartInc_i  first phase increment
//   StopInc_i   final phase increment
//   Step_i      step magnitude (0 behaves as 1)
//   Dwell_i     cycles each value is held (0 behaves as 1)
//   PhInc_o     phase increment to the NCO
//   Val_o       valid to the NCO
//   Busy_o      high whenever not IDLE
//   Done_o      one-cycle completion pulse
module sine_sweep_ctrl #(
    parameter int W       = 16,
    parameter int DWELL_W = 16
) (
    input  logic               Clk_i,
    input  logic               Rst_i,
    input  logic               Start_i,
    input  logic               Abort_i,
    input  logic [W-1:0]       StartInc_i,
    input  logic [W-1:0]       StopInc_i,
    input  logic [W-1:0]       Step_i,
    input  logic [DWELL_W-1:0] Dwell_i,
    output logic [W-1:0]       PhInc_o,
    output logic               Val_o,
    output logic               Busy_o,
    output logic               Done_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [W-1:0]       phinc_q, phinc_d;
    logic [W-1:0]       start_q, start_d;
    logic [W-1:0]       stop_q, stop_d;
    logic [W-1:0]       step_q, step_d;     // already forced to >= 1
    logic [DWELL_W-1:0] dm1_q, dm1_d;       // D-1, reload value of the counter
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic               up_q, up_d;
    logic               done_q, done_d;

    // Candidate next value, computed one bit wider so carry/borrow out of
    // W bits is visible and can be clamped to Stop.
    logic [W:0]   sum_w, dif_w;
    logic [W-1:0] next_inc;

    always_comb begin
        sum_w = {1'b0, phinc_q} + {1'b0, step_q};
        dif_w = {1'b0, phinc_q} - {1'b0, step_q};
        if (up_q) begin
            next_inc = (sum_w[W] || (sum_w[W-1:0] > stop_q)) ? stop_q : sum_w[W-1:0];
        end else begin
            next_inc = (dif_w[W] || (dif_w[W-1:0] < stop_q)) ? stop_q : dif_w[W-1:0];
        end
    end

    always_comb begin
        state_d = state_q;
        phinc_d = phinc_q;
        start_d = start_q;
        stop_d  = stop_q;
        step_d  = step_q;
        dm1_d   = dm1_q;
        cnt_d   = cnt_q;
        up_d    = up_q;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (Start_i && !Abort_i) begin
                    start_d = StartInc_i;
                    stop_d  = StopInc_i;
                    step_d  = (Step_i == '0) ? W'(1) : Step_i;
                    dm1_d   = (Dwell_i == '0) ? '0 : Dwell_i - DWELL_W'(1);
                    cnt_d   = (Dwell_i == '0) ? '0 : Dwell_i - DWELL_W'(1);
                    up_d    = (StopInc_i >= StartInc_i);
                    phinc_d = StartInc_i;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (Abort_i) begin
                    phinc_d = '0;
                    state_d = IDLE;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - DWELL_W'(1);
                end else if (phinc_q == stop_q) begin
`ifdef SWEEP_LOOP_EN
                    phinc_d = start_q;
                    cnt_d   = dm1_q;
                    done_d  = 1'b1;
`else
                    done_d  = 1'b1;
                    state_d = DONE;
`endif
                end else begin
                    phinc_d = next_inc;
                    cnt_d   = dm1_q;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk_i or posedge Rst_i) begin
        if (Rst_i) begin
            state_q <= IDLE;
            phinc_q <= '0;
            start_q <= '0;
            stop_q  <= '0;
            step_q  <= '0;
            dm1_q   <= '0;
            cnt_q   <= '0;
            up_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            phinc_q <= phinc_d;
            start_q <= start_d;
            stop_q  <= stop_d;
            step_q  <= step_d;
            dm1_q   <= dm1_d;
            cnt_q   <= cnt_d;
            up_q    <= up_d;
            done_q  <= done_d;
        end
    end

    // Outputs decode directly from registers only.
    assign PhInc_o = phinc_q;
    assign Val_o   = (state_q == RUN);
    assign Busy_o  = (state_q != IDLE);
    assign Done_o  = done_q;

endmodule

// File: tb/tb_sine_sweep_ctrl.sv
module tb_sine_sweep_ctrl;

    localparam int W = 16;
    localparam int DWELL_W = 16;

    logic               Clk_i = 1'b0;
    logic               Rst_i = 1'b1;
    logic               Start_i = 1'b0;
    logic               Abort_i = 1'b0;
    logic [W-1:0]       StartInc_i = '0;
    logic [W-1:0]       StopInc_i = '0;
    logic [W-1:0]       Step_i = '0;
    logic [DWELL_W-1:0] Dwell_i = '0;
    logic [W-1:0]       PhInc_o;
    logic               Val_o;
    logic               Busy_o;
    logic               Done_o;

    int checks = 0;
    int failures = 0;

    sine_sweep_ctrl #(.W(W), .DWELL_W(DWELL_W)) dut (
        .Clk_i(Clk_i), .Rst_i(Rst_i), .Start_i(Start_i), .Abort_i(Abort_i),
        .StartInc_i(StartInc_i), .StopInc_i(StopInc_i), .Step_i(Step_i),
        .Dwell_i(Dwell_i), .PhInc_o(PhInc_o), .Val_o(Val_o),
        .Busy_o(Busy_o), .Done_o(Done_o)
    );

    always #5 Clk_i = ~Clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Wait for the next sampling point (falling edge) and check all outputs.
    task automatic cyc(input string tag, input logic [W-1:0] ph, input logic val,
                       input logic done, input logic busy);
        @(negedge Clk_i);
        chk({tag, ".ph"},   32'(PhInc_o), 32'(ph));
        chk({tag, ".val"},  32'(Val_o),   32'(val));
        chk({tag, ".done"}, 32'(Done_o),  32'(done));
        chk({tag, ".busy"}, 32'(Busy_o),  32'(busy));
    endtask

    // Present Start_i for exactly one rising edge; returns just after it.
    task automatic go(input logic [W-1:0] s, input logic [W-1:0] e,
                      input logic [W-1:0] st, input logic [DWELL_W-1:0] d);
        @(negedge Clk_i);
        StartInc_i = s; StopInc_i = e; Step_i = st; Dwell_i = d;
        Start_i = 1'b1;
        @(posedge Clk_i);
        #1 Start_i = 1'b0;
    endtask

    task automatic abort_now();
        Abort_i = 1'b1;
        @(posedge Clk_i);
        #1 Abort_i = 1'b0;
    endtask

    initial begin
        #12;
        chk("reset.ph",   32'(PhInc_o), 0);
        chk("reset.val",  32'(Val_o),   0);
        chk("reset.busy", 32'(Busy_o),  0);
        chk("reset.done", 32'(Done_o),  0);
        @(negedge Clk_i);
        Rst_i = 1'b0;

`ifdef SWEEP_LOOP_EN
        go(16'h0010, 16'h0030, 16'h0010, 16'd3);
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 9; i++)
                cyc("loop", 16'h10 * (i/3 + 1), 1'b1, (r > 0 && i == 0), 1'b1);
        end
        cyc("loop.reload", 16'h10, 1'b1, 1'b1, 1'b1);
        abort_now();
        cyc("loop.abort", 16'h0, 1'b0, 1'b0, 1'b0);
`else
        // Ascending sweep
        go(16'h0010, 16'h0030, 16'h0010, 16'd3);
        for (int i = 0; i < 9; i++)
            cyc("asc", 16'h10 * (i/3 + 1), 1'b1, 1'b0, 1'b1);
        cyc("asc.done", 16'h30, 1'b0, 1'b1, 1'b1);
        cyc("asc.idle", 16'h30, 1'b0, 1'b0, 1'b0);

        // Descending with clamp to Stop
        go(16'h0030, 16'h0005, 16'h0010, 16'd1);
        cyc("dsc0", 16'h30, 1'b1, 1'b0, 1'b1);
        cyc("dsc1", 16'h20, 1'b1, 1'b0, 1'b1);
        cyc("dsc2", 16'h10, 1'b1, 1'b0, 1'b1);
        cyc("dsc3", 16'h05, 1'b1, 1'b0, 1'b1);
        cyc("dsc.done", 16'h05, 1'b0, 1'b1, 1'b1);
        cyc("dsc.idle", 16'h05, 1'b0, 1'b0, 1'b0);

        // W-bit overflow clamp, Dwell=0 acts as 1
        go(16'hFFF0, 16'hFFFF, 16'h0020, 16'd0);
        cyc("ovf0", 16'hFFF0, 1'b1, 1'b0, 1'b1);
        cyc("ovf1", 16'hFFFF, 1'b1, 1'b0, 1'b1);
        cyc("ovf.done", 16'hFFFF, 1'b0, 1'b1, 1'b1);
        cyc("ovf.idle", 16'hFFFF, 1'b0, 1'b0, 1'b0);

        // Step=0 acts as 1
        go(16'h0100, 16'h0102, 16'h0000, 16'd1);
        cyc("stp0", 16'h100, 1'b1, 1'b0, 1'b1);
        cyc("stp1", 16'h101, 1'b1, 1'b0, 1'b1);
        cyc("stp2", 16'h102, 1'b1, 1'b0, 1'b1);
        cyc("stp.done", 16'h102, 1'b0, 1'b1, 1'b1);

        // Abort on 2nd cycle of the 0x20 dwell
        go(16'h0010, 16'h0030, 16'h0010, 16'd3);
        for (int i = 0; i < 5; i++)
            cyc("abt", 16'h10 * (i/3 + 1), 1'b1, 1'b0, 1'b1);
        abort_now();
        cyc("abt.out", 16'h0, 1'b0, 1'b0, 1'b0);
        cyc("abt.nodone", 16'h0, 1'b0, 1'b0, 1'b0);

        // Start and Abort together in IDLE: no start
        @(negedge Clk_i);
        StartInc_i = 16'h0040; StopInc_i = 16'h0050;
        Start_i = 1'b1; Abort_i = 1'b1;
        @(posedge Clk_i);
        #1 Start_i = 1'b0; Abort_i = 1'b0;
        cyc("sa.idle", 16'h0, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset mid-sweep
        go(16'h0010, 16'h0030, 16'h0010, 16'd3);
        cyc("rst.run", 16'h10, 1'b1, 1'b0, 1'b1);
        #2 Rst_i = 1'b1;
        #1;
        chk("rst.async.ph",   32'(PhInc_o), 0);
        chk("rst.async.val",  32'(Val_o),   0);
        chk("rst.async.busy", 32'(Busy_o),  0);
        #1 Rst_i = 1'b0;
        go(16'h0030, 16'h0030, 16'h0010, 16'd2);
        cyc("eq0", 16'h30, 1'b1, 1'b0, 1'b1);
        cyc("eq1", 16'h30, 1'b1, 1'b0, 1'b1);
        cyc("eq.done", 16'h30, 1'b0, 1'b1, 1'b1);
        cyc("eq.idle", 16'h30, 1'b0, 1'b0, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
